audio_stream_hub: RTL and testbench
===================================

# audio_stream_hub

Parametrised Avalon-ST bridge between the audio codec IP channel ports and the core. Replaces per-channel left/right wiring with NCH generic channels. Each channel has an ADC→core record FIFO and a core→DAC playback FIFO. Adds runtime mode select (normal / loopback / mute), per-channel attenuation and saturating overrun counters.

## Interface
- NCH, default 2: number of audio channels (index 0 = left, 1 = right).
- DW, default 16: sample width, two's complement.
- DEPTH, default 8: entries per FIFO; power of two, ≥2.
- i_clk  in  1  system clock (50 MHz).
- i_rst_n  in  1  reset; one clock, asynchronous, active-low.
- i_mode  in  2  0 NORMAL, 1 LOOPBACK, 2 MUTE, 3 treated as NORMAL.
- i_atten  in  3  arithmetic right-shift applied to samples sent to DAC.
- from_adc_data  in  NCH×DW  codec ADC source data.
- from_adc_valid  in  NCH  codec ADC source valid.
- from_adc_ready  out  NCH  ready to codec ADC source.
- o_rec_data  out  NCH×DW  record samples to core.
- o_rec_valid  out  NCH  record valid.
- i_rec_ready  in  NCH  core accepts record sample.
- i_play_data  in  NCH×DW  playback samples from core.
- i_play_valid  in  NCH  playback valid.
- o_play_ready  out  NCH  hub accepts playback sample.
- to_dac_data  out  NCH×DW  codec DAC sink data.
- to_dac_valid  out  NCH  codec DAC sink valid.
- to_dac_ready  in  NCH  codec DAC sink ready.
- o_drop_cnt  out  NCH×8  per-channel ADC overrun count.

## Operation
- Transfer on any port = valid & ready at a rising edge.
- from_adc_ready is a register: 0 in reset, 1 from the first edge after reset release, thereafter constant 1. Codec samples are never back-pressured.
- ADC sample arriving when record FIFO full and not popped that cycle: dropped, o_drop_cnt[c] += 1, saturates at 255. Full with simultaneous pop: push accepted, no drop.
- NORMAL: ADC FIFO → o_rec_*; i_play_* → DAC FIFO → to_dac_*. o_play_ready = DAC FIFO not full.
- LOOPBACK: ADC FIFO head is popped into DAC FIFO whenever DAC FIFO not full; o_rec_valid = 0; o_play_ready = 0.
- MUTE: record path as NORMAL; play samples accepted and discarded; to_dac_valid = 1 with to_dac_data = 0.
- DAC output data = FIFO head >>> i_atten (sign-preserving, width DW, no rounding). Attenuation is applied at output, so i_atten changes affect the head sample immediately.
- Mode change (i_mode registered value differs from previous): all DAC FIFOs flushed on the following edge. Record FIFOs and counters retained.
- Channels are fully independent; no cross-channel alignment.

## Timing
- Reset values: all valids 0, from_adc_ready 0, o_play_ready 0, data outputs 0, o_drop_cnt 0, FIFOs empty.
- FIFOs are registered, no bypass. A sample pushed at edge t is visible as valid after edge t. Pop at edge t+1 at the earliest.
- NORMAL record latency ADC→o_rec_valid: 1 cycle. LOOPBACK ADC→to_dac_valid: 2 cycles.
- Simultaneous push and pop on an empty FIFO: push only (pop invalid). On a partially filled FIFO: count unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty is tracked with a separate count of log2(DEPTH)+1 bits.
- Reset asserted mid-transfer: state cleared asynchronously, and the in-flight sample is lost.

## Structure
- Package audio_hub_pkg: mode enum (MODE_NORMAL, MODE_LOOPBACK, MODE_MUTE), DROP_CNT_W = 8.
- Sub-module audio_sample_fifo (DW, DEPTH), with push/pop/flush/full/empty/count. 2·NCH instances are generated in a for-generate.
- Top contains per-channel mode muxing, attenuation and the counter.

## Test plan
- Reset, then NORMAL: ADC ch0 writes 0x1234 and the core holds i_rec_ready = 1 → o_rec_data[0] = 0x1234 with o_rec_valid one cycle after the push; from_adc_ready = 1 throughout.
- NORMAL with i_rec_ready = 0: 10 ADC samples on ch1 with DEPTH = 8 → 8 stored, o_drop_cnt[1] = 2; 300 further drops → counter holds 255.
- NORMAL playback: i_atten = 2, play 0x8000 and 0x7FFC with to_dac_ready = 1 → DAC sees 0xE000 then 0x1FFF. o_play_ready falls when the FIFO is full and to_dac_ready = 0.
- LOOPBACK: ADC 0x0042 on ch0 → to_dac_data[0] = 0x0042 two cycles later; o_rec_valid stays 0 and o_play_ready stays 0.
- MUTE after NORMAL with 5 queued DAC samples: DAC FIFO flushed, to_dac_data = 0 and to_dac_valid = 1; record path still delivers samples.
- Assert i_rst_n low mid-stream with FIFOs half full → all valids 0 and counters 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/audio_hub_pkg.sv
// audio_hub_pkg: shared mode encoding and counter width for the audio stream hub.
package audio_hub_pkg;
  typedef enum logic [1:0] {
    MODE_NORMAL   = 2'd0,
    MODE_LOOPBACK = 2'd1,
    MODE_MUTE     = 2'd2
  } mode_e;
  localparam int DROP_CNT_W = 8;
  // The unused encoding 3 behaves as NORMAL.
  function automatic mode_e decode_mode(input logic [1:0] m);
    return m == 2'd1 ? MODE_LOOPBACK : m == 2'd2 ? MODE_MUTE : MODE_NORMAL;
  endfunction
endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: registered sample FIFO with flush; pop on empty is ignored.
module audio_sample_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [DW-1:0]            data_i,
  output logic [DW-1:0]            data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign count_o = cnt_q;
  assign do_pop  = pop_i & !empty_o;
  assign do_push = push_i & (!full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q];
  assign wr_d    = flush_i ? '0 : wr_q + AW'(do_push);
  assign rd_d    = flush_i ? '0 : rd_q + AW'(do_pop);
  assign cnt_d   = flush_i ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/audio_stream_hub.sv
// audio_stream_hub: NCH-channel Avalon-ST bridge between codec ADC/DAC ports and the core,
// with record/playback FIFOs, mode select, DAC attenuation and ADC overrun counters.
module audio_stream_hub
  import audio_hub_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [1:0]                i_mode,
  input  logic [2:0]                i_atten,
  input  logic [NCH*DW-1:0]         from_adc_data,
  input  logic [NCH-1:0]            from_adc_valid,
  output logic [NCH-1:0]            from_adc_ready,
  output logic [NCH*DW-1:0]         o_rec_data,
  output logic [NCH-1:0]            o_rec_valid,
  input  logic [NCH-1:0]            i_rec_ready,
  input  logic [NCH*DW-1:0]         i_play_data,
  input  logic [NCH-1:0]            i_play_valid,
  output logic [NCH-1:0]            o_play_ready,
  output logic [NCH*DW-1:0]         to_dac_data,
  output logic [NCH-1:0]            to_dac_valid,
  input  logic [NCH-1:0]            to_dac_ready,
  output logic [NCH*DROP_CNT_W-1:0] o_drop_cnt
);
  mode_e mode_q, mode_d, prev_q;
  logic  run_q, flush;
  assign mode_d         = decode_mode(i_mode);
  assign flush          = mode_q != prev_q;
  assign from_adc_ready = {NCH{run_q}};
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q <= MODE_NORMAL;
      prev_q <= MODE_NORMAL;
      run_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      prev_q <= mode_q;
      run_q  <= 1'b1;
    end
  end
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DW-1:0]            rec_head, dac_head, dac_in;
    logic signed [DW-1:0]     dac_att;
    logic                     rec_full, rec_empty, dac_full, dac_empty;
    logic                     adc_fire, rec_pop, dac_push, dac_pop, drop;
    logic [$clog2(DEPTH):0]   rec_cnt, dac_cnt;
    logic                     unused_cnt;
    logic [DROP_CNT_W-1:0]    drop_q, drop_d;
    assign unused_cnt = ^{rec_cnt, dac_cnt};
    assign adc_fire   = from_adc_valid[c] & run_q;
    // In loopback the record head moves straight into the DAC FIFO while it has room.
    assign rec_pop    = !rec_empty & (mode_q == MODE_LOOPBACK ? !dac_full : i_rec_ready[c]);
    assign drop       = adc_fire & rec_full & !rec_pop;
    assign dac_push   = mode_q == MODE_LOOPBACK ? rec_pop
                      : mode_q == MODE_NORMAL & i_play_valid[c] & o_play_ready[c];
    assign dac_pop    = mode_q != MODE_MUTE & to_dac_ready[c];
    assign dac_in     = mode_q == MODE_LOOPBACK ? rec_head : i_play_data[c*DW +: DW];
    assign dac_att    = $signed(dac_head) >>> i_atten;
    assign drop_d     = (drop && drop_q != '1) ? drop_q + DROP_CNT_W'(1) : drop_q;
    assign o_rec_valid[c]                     = mode_q != MODE_LOOPBACK & !rec_empty;
    assign o_rec_data[c*DW +: DW]             = rec_head;
    assign o_play_ready[c]                    = run_q & (mode_q == MODE_MUTE | mode_q == MODE_NORMAL & !dac_full);
    assign to_dac_valid[c]                    = mode_q == MODE_MUTE | !dac_empty;
    assign to_dac_data[c*DW +: DW]            = mode_q == MODE_MUTE ? '0 : dac_att;
    assign o_drop_cnt[c*DROP_CNT_W +: DROP_CNT_W] = drop_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) drop_q <= '0;
      else          drop_q <= drop_d;
    end
    audio_sample_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rec (
      .clk_i   (i_clk),
      .rst_ni  (i_rst_n),
      .push_i  (adc_fire),
      .pop_i   (rec_pop),
      .flush_i (1'b0),
      .data_i  (from_adc_data[c*DW +: DW]),
      .data_o  (rec_head),
      .full_o  (rec_full),
      .empty_o (rec_empty),
      .count_o (rec_cnt)
    );
    audio_sample_fifo #(.DW(DW), .DEPTH(DEPTH)) u_dac (
      .clk_i   (i_clk),
      .rst_ni  (i_rst_n),
      .push_i  (dac_push),
      .pop_i   (dac_pop),
      .flush_i (flush),
      .data_i  (dac_in),
      .data_o  (dac_head),
      .full_o  (dac_full),
      .empty_o (dac_empty),
      .count_o (dac_cnt)
    );
  end
endmodule

// File: tb/tb_audio_stream_hub.sv
// tb_audio_stream_hub: directed plus randomized checks of audio_stream_hub against a queue-based model.
module tb_audio_stream_hub;
  localparam int NCH = 2, DW = 16, DEPTH = 8;
  logic              i_clk, i_rst_n;
  logic [1:0]        i_mode;
  logic [2:0]        i_atten;
  logic [NCH*DW-1:0] from_adc_data, o_rec_data, i_play_data, to_dac_data;
  logic [NCH-1:0]    from_adc_valid, from_adc_ready, o_rec_valid, i_rec_ready;
  logic [NCH-1:0]    i_play_valid, o_play_ready, to_dac_valid, to_dac_ready;
  logic [NCH*8-1:0]  o_drop_cnt;
  int total = 0, bad = 0;
  audio_stream_hub #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(i_mode), .i_atten(i_atten),
    .from_adc_data(from_adc_data), .from_adc_valid(from_adc_valid), .from_adc_ready(from_adc_ready),
    .o_rec_data(o_rec_data), .o_rec_valid(o_rec_valid), .i_rec_ready(i_rec_ready),
    .i_play_data(i_play_data), .i_play_valid(i_play_valid), .o_play_ready(o_play_ready),
    .to_dac_data(to_dac_data), .to_dac_valid(to_dac_valid), .to_dac_ready(to_dac_ready),
    .o_drop_cnt(o_drop_cnt)
  );
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  // Reference model: sample queues per channel, mode as seen after the mode register.
  typedef logic [DW-1:0] sq_t[$];
  sq_t rq[NCH];
  sq_t dq[NCH];
  int  m_mode, m_prev, m_drop[NCH];
  bit  m_run;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      rq[c].delete();
      dq[c].delete();
      m_drop[c] = 0;
    end
    m_mode = 0;
    m_prev = 0;
    m_run  = 1'b0;
  endtask
  task automatic model_edge();
    bit flush;
    flush = m_mode != m_prev;
    for (int c = 0; c < NCH; c++) begin
      bit rpop, dpop, pacc;
      logic [DW-1:0] h, t;
      rpop = rq[c].size() > 0 && (m_mode == 1 ? dq[c].size() < DEPTH : i_rec_ready[c] == 1'b1);
      dpop = m_mode != 2 && dq[c].size() > 0 && to_dac_ready[c] == 1'b1;
      pacc = m_run && m_mode == 0 && dq[c].size() < DEPTH && i_play_valid[c] == 1'b1;
      h = '0;
      if (rpop) h = rq[c].pop_front();
      if (m_run && from_adc_valid[c]) begin
        if (rq[c].size() < DEPTH) rq[c].push_back(from_adc_data[c*DW +: DW]);
        else if (m_drop[c] < 255) m_drop[c]++;
      end
      if (flush) dq[c].delete();
      else begin
        if (dpop) t = dq[c].pop_front();
        if (m_mode == 1 && rpop) dq[c].push_back(h);
        if (pacc) dq[c].push_back(i_play_data[c*DW +: DW]);
      end
    end
    m_prev = m_mode;
    m_mode = (i_mode == 2'd1 || i_mode == 2'd2) ? int'(i_mode) : 0;
    m_run  = 1'b1;
  endtask
  task automatic check_all(string tag);
    logic [NCH-1:0]    e_rv, e_pr, e_dv;
    logic [NCH*DW-1:0] e_rd, e_dd;
    logic [NCH*8-1:0]  e_dc;
    logic signed [DW-1:0] s;
    for (int c = 0; c < NCH; c++) begin
      e_rv[c] = m_mode != 1 && rq[c].size() > 0;
      e_rd[c*DW +: DW] = rq[c].size() > 0 ? rq[c][0] : '0;
      e_pr[c] = m_run && (m_mode == 2 || (m_mode == 0 && dq[c].size() < DEPTH));
      e_dv[c] = m_mode == 2 || dq[c].size() > 0;
      s = dq[c].size() > 0 ? dq[c][0] : '0;
      s = s >>> i_atten;
      e_dd[c*DW +: DW] = m_mode == 2 ? '0 : s;
      e_dc[c*8 +: 8] = 8'(m_drop[c]);
    end
    chk({tag, " adc_ready"}, 64'(from_adc_ready), 64'({NCH{m_run}}));
    chk({tag, " rec_valid"}, 64'(o_rec_valid), 64'(e_rv));
    chk({tag, " rec_data"}, 64'(o_rec_data), 64'(e_rd));
    chk({tag, " play_ready"}, 64'(o_play_ready), 64'(e_pr));
    chk({tag, " dac_valid"}, 64'(to_dac_valid), 64'(e_dv));
    chk({tag, " dac_data"}, 64'(to_dac_data), 64'(e_dd));
    chk({tag, " drop_cnt"}, 64'(o_drop_cnt), 64'(e_dc));
  endtask
  task automatic tick(string tag);
    model_edge();
    @(posedge i_clk);
    #1;
    check_all(tag);
  endtask
  initial begin
    i_rst_n = 1'b1; i_mode = 2'd0; i_atten = 3'd0;
    from_adc_data = '0; from_adc_valid = '0; i_rec_ready = '0;
    i_play_data = '0; i_play_valid = '0; to_dac_ready = '0;
    #2 i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    model_reset();
    chk("reset adc_ready", 64'(from_adc_ready), 64'(0));
    chk("reset play_ready", 64'(o_play_ready), 64'(0));
    chk("reset valids", 64'({o_rec_valid, to_dac_valid}), 64'(0));
    chk("reset data", 64'({o_rec_data, to_dac_data}), 64'(0));
    check_all("reset");
    #3 i_rst_n = 1'b1;
    tick("idle");
    chk("adc_ready up", 64'(from_adc_ready), 64'(2'b11));
    // NORMAL record, core always ready
    i_rec_ready = 2'b11;
    from_adc_data[15:0] = 16'h1234; from_adc_valid = 2'b01;
    tick("rec push");
    from_adc_valid = 2'b00;
    chk("rec0 valid", 64'(o_rec_valid[0]), 64'(1));
    chk("rec0 data", 64'(o_rec_data[15:0]), 64'(16'h1234));
    tick("rec pop");
    chk("rec0 drained", 64'(o_rec_valid[0]), 64'(0));
    // overrun on ch1
    i_rec_ready = 2'b00; from_adc_valid = 2'b10;
    for (int i = 0; i < 10; i++) begin
      from_adc_data[31:16] = 16'($urandom);
      tick("overrun");
    end
    chk("drop1 after 10", 64'(o_drop_cnt[15:8]), 64'(2));
    chk("drop0 untouched", 64'(o_drop_cnt[7:0]), 64'(0));
    for (int i = 0; i < 300; i++) tick("saturate");
    chk("drop1 saturated", 64'(o_drop_cnt[15:8]), 64'(255));
    from_adc_valid = 2'b00; i_rec_ready = 2'b11;
    repeat (8) tick("drain");
    // NORMAL playback with attenuation
    i_atten = 3'd2; to_dac_ready = 2'b00;
    i_play_data[15:0] = 16'h8000; i_play_valid = 2'b01;
    tick("play a");
    i_play_data[15:0] = 16'h7FFC;
    tick("play b");
    i_play_valid = 2'b00;
    chk("dac0 first", 64'(to_dac_data[15:0]), 64'(16'hE000));
    to_dac_ready = 2'b01;
    tick("dac pop a");
    chk("dac0 second", 64'(to_dac_data[15:0]), 64'(16'h1FFF));
    tick("dac pop b");
    chk("dac0 empty", 64'(to_dac_valid[0]), 64'(0));
    to_dac_ready = 2'b00; i_play_valid = 2'b01;
    for (int i = 0; i < 8; i++) begin
      i_play_data[15:0] = 16'($urandom);
      tick("fill dac");
    end
    chk("play_ready full", 64'(o_play_ready[0]), 64'(0));
    i_play_valid = 2'b00; to_dac_ready = 2'b01;
    repeat (3) tick("dac to 5");
    to_dac_ready = 2'b00;
    // MUTE flushes the 5 queued samples
    i_mode = 2'd2;
    tick("mute enter");
    chk("mute dac valid", 64'(to_dac_valid[0]), 64'(1));
    chk("mute dac data", 64'(to_dac_data[15:0]), 64'(0));
    tick("mute flush");
    i_rec_ready = 2'b00; from_adc_data[15:0] = 16'h0BEE; from_adc_valid = 2'b01;
    tick("mute rec");
    from_adc_valid = 2'b00;
    chk("mute rec data", 64'(o_rec_data[15:0]), 64'(16'h0BEE));
    i_rec_ready = 2'b11; i_play_valid = 2'b01;
    tick("mute play");
    chk("mute play_ready", 64'(o_play_ready[0]), 64'(1));
    i_play_valid = 2'b00; i_mode = 2'd0;
    tick("normal back");
    chk("flushed by mute", 64'(to_dac_valid[0]), 64'(0));
    tick("normal settle");
    // LOOPBACK
    i_atten = 3'd0; i_mode = 2'd1;
    tick("lb enter");
    tick("lb flush");
    from_adc_data[15:0] = 16'h0042; from_adc_valid = 2'b01;
    tick("lb push");
    from_adc_valid = 2'b00;
    chk("lb dac not yet", 64'(to_dac_valid[0]), 64'(0));
    tick("lb move");
    chk("lb dac data", 64'(to_dac_data[15:0]), 64'(16'h0042));
    chk("lb dac valid", 64'(to_dac_valid[0]), 64'(1));
    chk("lb rec_valid", 64'(o_rec_valid), 64'(0));
    chk("lb play_ready", 64'(o_play_ready), 64'(0));
    // randomized traffic across all modes
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) i_mode = 2'($urandom_range(0, 3));
      i_atten = 3'($urandom);
      from_adc_data = NCH*DW'($urandom); from_adc_valid = NCH'($urandom);
      i_play_data = NCH*DW'($urandom); i_play_valid = NCH'($urandom);
      i_rec_ready = NCH'($urandom); to_dac_ready = NCH'($urandom);
      tick("rnd");
    end
    // asynchronous reset with FIFOs partly filled
    i_mode = 2'd0; from_adc_valid = '0; i_play_valid = '0;
    tick("pre fill a");
    tick("pre fill b");
    i_rec_ready = '0; to_dac_ready = '0; from_adc_valid = 2'b11; i_play_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      from_adc_data = NCH*DW'($urandom); i_play_data = NCH*DW'($urandom);
      tick("half fill");
    end
    from_adc_valid = '0; i_play_valid = '0;
    #3 i_rst_n = 1'b0;
    #1;
    chk("async valids", 64'({o_rec_valid, to_dac_valid}), 64'(0));
    chk("async drops", 64'(o_drop_cnt), 64'(0));
    chk("async readies", 64'({from_adc_ready, o_play_ready}), 64'(0));
    model_reset();
    check_all("async");
    #2 i_rst_n = 1'b1;
    repeat (3) tick("post reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
